mem_arbiter: RTL

- Shares the single core memory port between instruction fetch (imem) and the execute-stage load/store unit (dmem).
- Sits between fetch/execute and the memory/bus interface.
- Returns mem_ready/mem_rdata to whichever requester holds the grant. The execute stage keeps its stall-on-not-ready behaviour unchanged.
- Arbitration is round-robin on conflict. One transaction is in flight at a time.

---
 rtl/mem_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Round-robin arbiter sharing one memory port between fetch (imem)
//             and load/store (dmem), one transaction in flight at a time.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int XLEN = 32,
    parameter int AW   = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              imem_valid,
    input  logic [AW-1:0]     imem_addr,
    output logic              imem_ready,
    output logic [XLEN-1:0]   imem_rdata,

    input  logic              dmem_valid,
    input  logic [AW-1:0]     dmem_addr,
    input  logic [XLEN-1:0]   dmem_wdata,
    input  logic [XLEN/8-1:0] dmem_wstrb,
    output logic              dmem_ready,
    output logic [XLEN-1:0]   dmem_rdata,

    output logic              mem_valid,
    output logic              mem_instr,
    output logic [AW-1:0]     mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wstrb,
    input  logic              mem_ready,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_BUSY_I  = 2'd1;
    localparam logic [1:0] c_BUSY_D  = 2'd2;
    localparam logic       c_GRANT_I = 1'b0;
    localparam logic       c_GRANT_D = 1'b1;

    logic [1:0]        state_q,      state_d;
    logic              last_grant_q, last_grant_d;
    logic [AW-1:0]     addr_q,       addr_d;
    logic [XLEN-1:0]   wdata_q,      wdata_d;
    logic [XLEN/8-1:0] wstrb_q,      wstrb_d;
    logic              instr_q,      instr_d;

    // State register together with the request latch
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= c_IDLE;
            last_grant_q <= c_GRANT_I;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            instr_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            instr_q      <= instr_d;
        end
    end

    // Next-state: requests are only sampled in IDLE, so latched fields hold
    // for the whole transaction and a valid seen in the completion cycle is
    // not re-granted.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        instr_d      = instr_q;
        case (state_q)
            c_IDLE: begin
                if (imem_valid && (!dmem_valid || last_grant_q == c_GRANT_D)) begin
                    state_d      = c_BUSY_I;
                    last_grant_d = c_GRANT_I;
                    addr_d       = imem_addr;
                    wdata_d      = '0;
                    wstrb_d      = '0;
                    instr_d      = 1'b1;
                end else if (dmem_valid) begin
                    state_d      = c_BUSY_D;
                    last_grant_d = c_GRANT_D;
                    addr_d       = dmem_addr;
                    wdata_d      = dmem_wdata;
                    wstrb_d      = dmem_wstrb;
                    instr_d      = 1'b0;
                end
            end
            c_BUSY_I, c_BUSY_D: begin
                if (mem_ready) begin
                    state_d = c_IDLE;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    // Ready is suppressed under reset so an abandoned transaction never pulses
    always_comb begin
        mem_valid  = (state_q == c_BUSY_I) || (state_q == c_BUSY_D);
        mem_instr  = instr_q;
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
        mem_wstrb  = wstrb_q;
        imem_ready = (state_q == c_BUSY_I) && mem_ready && !rst;
        dmem_ready = (state_q == c_BUSY_D) && mem_ready && !rst;
        imem_rdata = mem_rdata;
        dmem_rdata = mem_rdata;
    end

endmodule

`default_nettype wire
